// File: rtl/tetromino_bag_randomizer.sv
// 7-bag piece-index randomizer feeding generate_tetromino.
// Ports: clk, rst (sync, active-low), req/valid handshake, seed_load/seed,
//   idx_out (0..6), bag_remaining (7..0), pieces_issued (wrapping count).
module tetromino_bag_randomizer #(
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
   parameter int unsigned MAX_RETRY    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        seed_load,
   input  logic [15:0] seed,
   output logic [2:0]  idx_out,
   output logic        valid,
   output logic [2:0]  bag_remaining,
   output logic [15:0] pieces_issued
);

   localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
   // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic {
      S_DRAW,
      S_READY
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    lfsr_q, lfsr_d;
   logic [6:0]     mask_q, mask_d;
   logic [RW-1:0]  retry_q, retry_d;
   logic [2:0]     idx_q, idx_d;
   logic           valid_q, valid_d;
   logic [15:0]    issued_q, issued_d;

   logic [15:0]    lfsr_step;
   logic [2:0]     cand;
   logic [7:0]     taken;
   logic           cand_ok;
   logic           bag_full;
   logic           draw_take;
   logic [2:0]     fb_idx;
   logic [2:0]     pick;
   logic [2:0]     drawn_cnt;

   assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
   assign cand      = lfsr_q[2:0];
   // Bit 7 is permanently "taken" so candidate 7 is rejected like a drawn piece.
   assign taken     = {1'b1, mask_q};
   assign cand_ok   = !taken[cand];
   assign bag_full  = (mask_q == 7'h7F);
   assign draw_take = (state_q == S_DRAW) && !bag_full &&
                      (cand_ok || (retry_q == RETRY_LAST));
   assign pick      = cand_ok ? cand : fb_idx;

   // Lowest-numbered piece still in the bag.
   always_comb begin
      fb_idx = 3'd0;
      for (int k = 6; k >= 0; k--) begin
         if (!mask_q[k]) fb_idx = 3'(k);
      end
   end

   always_comb begin
      drawn_cnt = 3'd0;
      for (int k = 0; k < 7; k++) begin
         drawn_cnt = drawn_cnt + {2'b00, mask_q[k]};
      end
   end

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_DRAW;
         lfsr_q   <= SEED_DEFAULT;
         mask_q   <= 7'h00;
         retry_q  <= '0;
         idx_q    <= 3'd0;
         valid_q  <= 1'b0;
         issued_q <= 16'h0000;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         mask_q   <= mask_d;
         retry_q  <= retry_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         issued_q <= issued_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_DRAW:  if (draw_take) state_d = S_READY;
         S_READY: if (req) state_d = S_DRAW;
         default: state_d = S_DRAW;
      endcase
      if (seed_load) state_d = S_DRAW;
   end

   // Datapath / output logic
   always_comb begin
      lfsr_d   = lfsr_step;
      mask_d   = mask_q;
      retry_d  = retry_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      issued_d = issued_q;
      if (seed_load) begin
         // A zero seed would lock the LFSR, so substitute the default.
         lfsr_d  = (seed == 16'h0000) ? SEED_DEFAULT : seed;
         mask_d  = 7'h00;
         retry_d = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            S_DRAW: begin
               if (bag_full) begin
                  mask_d = 7'h00;
               end else if (draw_take) begin
                  idx_d   = pick;
                  mask_d  = mask_q | (7'd1 << pick);
                  valid_d = 1'b1;
                  retry_d = '0;
               end else begin
                  retry_d = retry_q + 1'b1;
               end
            end
            S_READY: begin
               if (req) begin
                  valid_d  = 1'b0;
                  issued_d = issued_q + 16'd1;
               end
            end
            default: valid_d = 1'b0;
         endcase
      end
   end

   assign idx_out       = idx_q;
   assign valid         = valid_q;
   assign bag_remaining = 3'd7 - drawn_cnt;
   assign pieces_issued = issued_q;

endmodule

// File: tb/tb_tetromino_bag_randomizer.sv
// Directed bench for tetromino_bag_randomizer.
// Checks reset, 7-bag permutations, seeding determinism and interrupts.
module tb_tetromino_bag_randomizer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [2:0]  idx_out;
   logic        valid;
   logic [2:0]  bag_remaining;
   logic [15:0] pieces_issued;

   int total = 0;
   int bad = 0;
   int max_gap = 0;
   logic [2:0] got[$];
   logic [2:0] bags[$];
   logic [2:0] ref_seq[$];

   tetromino_bag_randomizer dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .seed_load(seed_load),
      .seed(seed),
      .idx_out(idx_out),
      .valid(valid),
      .bag_remaining(bag_remaining),
      .pieces_issued(pieces_issued)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_idx"}, 32'(idx_out), 32'd0);
      chk({tag, "_bag"}, 32'(bag_remaining), 32'd7);
      chk({tag, "_issued"}, 32'(pieces_issued), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = 1'b0;
      seed_load = 1'b0;
      cycle();
      rst = 1'b1;
   endtask

   task automatic do_seed(input logic [15:0] s);
      seed = s;
      seed_load = 1'b1;
      cycle();
      seed_load = 1'b0;
   endtask

   // Hold req high and record each offered index that gets consumed.
   task automatic collect(input string tag, input int n);
      int cyc;
      int run;
      cyc = 0;
      run = 0;
      got.delete();
      bags.delete();
      max_gap = 0;
      req = 1'b1;
      while (got.size() < n && cyc < n * 12) begin
         if (valid) begin
            got.push_back(idx_out);
            bags.push_back(bag_remaining);
            run = 0;
         end else begin
            run++;
            if (run > max_gap) max_gap = run;
         end
         cycle();
         cyc++;
      end
      req = 1'b0;
      chk({tag, "_count"}, 32'(got.size()), 32'(n));
   endtask

   task automatic chk_perm(input string tag, input int base);
      logic [7:0] seen;
      seen = 8'h00;
      for (int i = 0; i < 7; i++) seen[got[base + i]] = 1'b1;
      chk(tag, 32'(seen), 32'h7F);
   endtask

   task automatic wait_valid(input string tag);
      int c;
      c = 0;
      while (!valid && c < 10) begin
         cycle();
         c++;
      end
      chk(tag, 32'(valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      cycle();
      chk_reset_vals("rst0");

      // req while valid=0 is ignored; first draw uses lfsr=ACE1 -> idx 1
      rst = 1'b1;
      req = 1'b1;
      cycle();
      req = 1'b0;
      chk("ign_issued", 32'(pieces_issued), 32'd0);
      chk("ign_valid", 32'(valid), 32'd1);
      chk("first_idx", 32'(idx_out), 32'd1);
      chk("first_bag", 32'(bag_remaining), 32'd6);
      cycle();
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_issued", 32'(pieces_issued), 32'd0);

      // 70 back-to-back handshakes
      do_reset();
      chk_reset_vals("rst1");
      collect("run70", 70);
      chk("run70_i0", 32'(got[0]), 32'd1);
      chk("run70_i1", 32'(got[1]), 32'd0);
      chk("run70_i2", 32'(got[2]), 32'd6);
      for (int b = 0; b < 10; b++)
         chk_perm($sformatf("run70_perm%0d", b), b * 7);
      for (int i = 0; i < 70; i++)
         chk($sformatf("run70_bag%0d", i), 32'(bags[i]), 32'(6 - (i % 7)));
      chk("run70_issued", 32'(pieces_issued), 32'd70);
      chk("run70_gap", 32'(max_gap <= 9), 32'd1);

      // Seed 1234 twice gives identical sequences
      do_seed(16'h1234);
      chk("s1234_valid", 32'(valid), 32'd0);
      chk("s1234_bag", 32'(bag_remaining), 32'd7);
      chk("s1234_issued", 32'(pieces_issued), 32'd70);
      collect("s1234a", 14);
      chk_perm("s1234a_perm0", 0);
      chk_perm("s1234a_perm1", 7);
      ref_seq = got;
      do_seed(16'h1234);
      collect("s1234b", 14);
      for (int i = 0; i < 14; i++)
         chk($sformatf("s1234_rep%0d", i), 32'(got[i]), 32'(ref_seq[i]));

      // Zero seed behaves like the default seed
      do_seed(16'h0000);
      collect("s0", 7);
      chk("s0_i0", 32'(got[0]), 32'd1);
      chk("s0_i1", 32'(got[1]), 32'd0);
      chk("s0_i2", 32'(got[2]), 32'd6);
      ref_seq = got;
      do_seed(16'hACE1);
      collect("sace1", 7);
      for (int i = 0; i < 7; i++)
         chk($sformatf("s0_vs_ace1_%0d", i), 32'(got[i]), 32'(ref_seq[i]));

      // Mid-bag seed_load with simultaneous req
      do_reset();
      collect("mid3", 3);
      wait_valid("mid_wait");
      seed = 16'h5A5A;
      seed_load = 1'b1;
      req = 1'b1;
      cycle();
      seed_load = 1'b0;
      req = 1'b0;
      chk("mid_valid", 32'(valid), 32'd0);
      chk("mid_issued", 32'(pieces_issued), 32'd3);
      chk("mid_bag", 32'(bag_remaining), 32'd7);
      collect("mid7", 7);
      chk_perm("mid_perm", 0);
      chk("mid_issued10", 32'(pieces_issued), 32'd10);

      // Mid-bag reset overrides a pending req
      do_reset();
      collect("rsti3", 3);
      wait_valid("rsti_wait");
      rst = 1'b0;
      req = 1'b1;
      cycle();
      rst = 1'b1;
      req = 1'b0;
      chk_reset_vals("rsti");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
